// File: rtl/window_shift_reg.sv
// Sliding window shift register: accepts a run of i_len samples and presents the
// last DEPTH of them as a packed window, flagging each shift once the window is full.
module window_shift_reg #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 9,
    parameter int LEN_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_run,
    input  logic [LEN_W-1:0]        i_len,
    input  logic                    i_valid,
    input  logic [DATA_W-1:0]       i_data,
    output logic                    o_ready,
    output logic [DATA_W*DEPTH-1:0] o_win,
    output logic                    o_win_valid,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int WIN_W  = DATA_W * DEPTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                winValid_q, winValid_d;
    logic                accept;

    assign o_ready     = (state_q == RUN);
    assign o_busy      = (state_q == RUN) || (state_q == DONE);
    assign o_done      = (state_q == DONE);
    assign o_win       = win_q;
    assign o_win_valid = winValid_q;
    assign accept      = i_valid & o_ready;

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        fill_d     = fill_q;
        winValid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_run) begin
                    if (i_len != '0) begin
                        len_d   = i_len;
                        win_d   = '0;
                        cnt_d   = '0;
                        fill_d  = '0;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    // Shift toward higher taps so tap 0 always holds the newest sample.
                    win_d  = {win_q[WIN_W-DATA_W-1:0], i_data};
                    cnt_d  = cnt_q + LEN_W'(1);
                    fill_d = (fill_q == FILL_W'(DEPTH)) ? fill_q : fill_q + FILL_W'(1);
                    winValid_d = (fill_d == FILL_W'(DEPTH));
                    if (cnt_d == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            win_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            fill_q     <= '0;
            winValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            fill_q     <= fill_d;
            winValid_q <= winValid_d;
        end
    end

endmodule

// File: tb/tb_window_shift_reg.sv
// Self-checking bench for window_shift_reg: a sample-queue model checked every cycle,
// plus hand-computed window/pulse expectations for the directed runs.
module tb_window_shift_reg;

    localparam int DW = 8;
    localparam int DP = 9;
    localparam int LW = 16;

    logic              clk;
    logic              rst;
    logic              i_run;
    logic [LW-1:0]     i_len;
    logic              i_valid;
    logic [DW-1:0]     i_data;
    logic              o_ready;
    logic [DW*DP-1:0]  o_win;
    logic              o_win_valid;
    logic              o_busy;
    logic              o_done;

    int passCnt  = 0;
    int totalCnt = 0;
    int pulseCnt = 0;
    bit checking = 0;

    logic [DW-1:0] samples[$];
    int  mLen      = 0;
    bit  mRunning  = 0;
    bit  mDone     = 0;
    bit  mWinValid = 0;

    int gapTab[12] = '{0, 1, 0, 2, 0, 0, 1, 0, 3, 0, 1, 0};

    window_shift_reg #(.DATA_W(DW), .DEPTH(DP), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .i_run(i_run), .i_len(i_len), .i_valid(i_valid),
        .i_data(i_data), .o_ready(o_ready), .o_win(o_win), .o_win_valid(o_win_valid),
        .o_busy(o_busy), .o_done(o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DW*DP-1:0] act,
                               input logic [DW*DP-1:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // The expected window is simply the most recent DEPTH samples of the run, zero-padded.
    function automatic logic [DW*DP-1:0] modelWindow();
        logic [DW*DP-1:0] w = '0;
        int n = samples.size();
        for (int k = 0; k < DP; k++)
            if (k < n) w[k*DW +: DW] = samples[n-1-k];
        return w;
    endfunction

    always @(posedge clk) begin
        checking <= 1'b1;
        if (rst) begin
            samples.delete();
            mLen = 0; mRunning = 0; mDone = 0; mWinValid = 0;
        end else begin
            mWinValid = 0;
            if (mDone) begin
                mDone = 0;
            end else if (mRunning) begin
                if (i_valid) begin
                    samples.push_back(i_data);
                    if (samples.size() >= DP) mWinValid = 1;
                    if (samples.size() == mLen) begin
                        mRunning = 0;
                        mDone = 1;
                    end
                end
            end else if (i_run) begin
                if (i_len != 0) begin
                    samples.delete();
                    mLen = int'(i_len);
                    mRunning = 1;
                end else begin
                    mDone = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("ready", {71'd0, o_ready}, {71'd0, mRunning});
            checkOutput("busy", {71'd0, o_busy}, {71'd0, mRunning | mDone});
            checkOutput("done", {71'd0, o_done}, {71'd0, mDone});
            checkOutput("win_valid", {71'd0, o_win_valid}, {71'd0, mWinValid});
            checkOutput("win", o_win, modelWindow());
            if (o_win_valid === 1'b1) pulseCnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic startRun(input int len);
        pulseCnt = 0;
        i_run = 1'b1;
        i_len = LW'(len);
        step();
        i_run = 1'b0;
    endtask

    task automatic applyStimulus(input int n, input int base, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                for (int g = 0; g < gapTab[i % 12]; g++) begin
                    i_valid = 1'b0;
                    step();
                end
            end
            i_valid = 1'b1;
            i_data  = DW'(base + i);
            step();
        end
        i_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_run = 1'b0; i_len = '0; i_valid = 1'b0; i_data = '0;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_win", o_win, '0);
        checkOutput("reset_busy", {71'd0, o_busy}, 72'd0);
        step();

        // Full window in one back-to-back run.
        startRun(9);
        applyStimulus(9, 1, 0);
        @(negedge clk);
        checkOutput("len9_win", o_win, 72'h010203040506070809);
        checkOutput("len9_wv", {71'd0, o_win_valid}, 72'd1);
        checkOutput("len9_done", {71'd0, o_done}, 72'd1);
        step();
        @(negedge clk);
        checkOutput("len9_busy_after", {71'd0, o_busy}, 72'd0);
        checkOutput("len9_pulses", 72'(pulseCnt), 72'd1);
        step();

        // Longer run with idle gaps between samples.
        startRun(12);
        applyStimulus(12, 1, 1);
        @(negedge clk);
        checkOutput("len12_win", o_win, 72'h0405060708090A0B0C);
        step();
        @(negedge clk);
        checkOutput("len12_pulses", 72'(pulseCnt), 72'd4);
        step();

        // Short run never fills the window.
        startRun(5);
        applyStimulus(5, 1, 0);
        @(negedge clk);
        checkOutput("len5_done", {71'd0, o_done}, 72'd1);
        checkOutput("len5_win", o_win, 72'h000000000102030405);
        step();
        @(negedge clk);
        checkOutput("len5_pulses", 72'(pulseCnt), 72'd0);
        step();

        // Zero length goes straight to DONE and leaves the taps alone.
        startRun(0);
        @(negedge clk);
        checkOutput("len0_done", {71'd0, o_done}, 72'd1);
        checkOutput("len0_ready", {71'd0, o_ready}, 72'd0);
        checkOutput("len0_win", o_win, 72'h000000000102030405);
        step(); step();

        // Reset in the middle of a run, then a clean run.
        startRun(9);
        applyStimulus(4, 8'h21, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_win", o_win, '0);
        checkOutput("midrst_busy", {71'd0, o_busy}, 72'd0);
        step();
        startRun(9);
        applyStimulus(9, 8'h11, 0);
        @(negedge clk);
        checkOutput("postrst_win", o_win, 72'h111213141516171819);
        step(); step();

        // i_run during RUN and i_valid during IDLE must both be ignored.
        startRun(3);
        i_run = 1'b1; i_len = LW'(1);
        step();
        i_run = 1'b0;
        applyStimulus(3, 8'h31, 0);
        step(); step();
        i_valid = 1'b1; i_data = 8'hEE;
        step(); step();
        i_valid = 1'b0;
        @(negedge clk);
        checkOutput("ignore_win", o_win, 72'h000000000000313233);
        checkOutput("ignore_busy", {71'd0, o_busy}, 72'd0);
        step();

        $display("[TB] %0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
